// File: rtl/hls_run_sequencer.sv
// Batch run sequencer: resets and starts N_CH DUT channels, measures cycles to
// done (or timeout) per channel, and streams one result record per channel per run.
module hls_run_sequencer #(
  parameter int N_CH     = 1,
  parameter int CNT_W    = 32,
  parameter int TIMEOUT  = 200000000,
  parameter int NUM_RUNS = 1,
  parameter int RUN_W    = 16,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  output logic              dut_rst_n,
  output logic [N_CH-1:0]   dut_start,
  input  logic [N_CH-1:0]   dut_done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [RUN_W-1:0]  res_run,
  output logic [CNT_W-1:0]  res_cycles,
  output logic [1:0]        res_status,
  output logic              busy,
  output logic              batch_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT, S_REPORT, S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] TO       = CNT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(NUM_RUNS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  state_t            state;
  logic              setup_cnt;
  logic [CNT_W-1:0]  cnt;
  logic [RUN_W-1:0]  run_idx;
  logic [N_CH-1:0]   captured;
  logic [CNT_W-1:0]  cap_cyc [N_CH];
  logic              cap_to  [N_CH];
  logic [CH_W-1:0]   rep_ch;

  logic              in_run;
  logic              at_limit;
  logic              run_over;
  logic [N_CH-1:0]   done_new;
  logic [N_CH-1:0]   flags_next;
  logic [CNT_W-1:0]  cyc_next [N_CH];
  logic              to_next  [N_CH];
  logic [CH_W-1:0]   next_ch;

  // A done seen in the timeout cycle is taken as completed; only channels
  // still silent at that point get the timeout record.
  always_comb begin
    in_run     = (state == S_START) || (state == S_WAIT);
    at_limit   = in_run && (cnt == TO);
    done_new   = in_run ? (dut_done & ~captured) : '0;
    flags_next = captured | done_new;
    run_over   = in_run && ((&flags_next) || at_limit);
    next_ch    = rep_ch + CH_W'(1);
    for (int i = 0; i < N_CH; i++) begin
      cyc_next[i] = cap_cyc[i];
      to_next[i]  = cap_to[i];
      if (done_new[i]) begin
        cyc_next[i] = cnt;
        to_next[i]  = 1'b0;
      end else if (!captured[i] && at_limit) begin
        cyc_next[i] = TO;
        to_next[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      setup_cnt  <= 1'b0;
      cnt        <= '0;
      run_idx    <= '0;
      captured   <= '0;
      rep_ch     <= '0;
      dut_rst_n  <= 1'b0;
      dut_start  <= '0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_run    <= '0;
      res_cycles <= '0;
      res_status <= '0;
      busy       <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      dut_start  <= '0;
      batch_done <= 1'b0;
      case (state)
        S_IDLE: begin
          dut_rst_n <= 1'b1;
          if (go) begin
            state     <= S_SETUP;
            run_idx   <= '0;
            busy      <= 1'b1;
            dut_rst_n <= 1'b0;
            setup_cnt <= 1'b0;
          end
        end
        S_SETUP: begin
          if (setup_cnt) begin
            state     <= S_START;
            dut_rst_n <= 1'b1;
            dut_start <= '1;
            cnt       <= CNT_W'(1);
            captured  <= '0;
          end else begin
            setup_cnt <= 1'b1;
          end
        end
        S_START, S_WAIT: begin
          for (int i = 0; i < N_CH; i++) begin
            cap_cyc[i] <= cyc_next[i];
            cap_to[i]  <= to_next[i];
          end
          captured <= flags_next;
          if (cnt != TO) cnt <= cnt + CNT_W'(1);
          if (run_over) begin
            state      <= S_REPORT;
            rep_ch     <= '0;
            res_valid  <= 1'b1;
            res_ch     <= '0;
            res_run    <= run_idx;
            res_cycles <= cyc_next[0];
            res_status <= {2{to_next[0]}};
          end else begin
            state <= S_WAIT;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            if (rep_ch == LAST_CH) begin
              res_valid <= 1'b0;
              if (run_idx != LAST_RUN) begin
                run_idx   <= run_idx + RUN_W'(1);
                state     <= S_SETUP;
                dut_rst_n <= 1'b0;
                setup_cnt <= 1'b0;
              end else begin
                state      <= S_FINISH;
                batch_done <= 1'b1;
              end
            end else begin
              rep_ch     <= next_ch;
              res_ch     <= next_ch;
              res_cycles <= cap_cyc[next_ch];
              res_status <= {2{cap_to[next_ch]}};
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Bench for hls_run_sequencer: directed done schedules per run, a record-level
// model of expected results, and a single compare process on the falling edge.
module tb_hls_run_sequencer;
  localparam int N_CH = 4, CNT_W = 16, TIMEOUT = 20, NUM_RUNS = 3, RUN_W = 4;
  localparam int NEVER = 1000;

  logic             clock = 1'b0, reset = 1'b0, go = 1'b0, res_ready = 1'b0;
  logic [N_CH-1:0]  dut_done = '0;
  logic             dut_rst_n, res_valid, busy, batch_done;
  logic [N_CH-1:0]  dut_start;
  logic [1:0]       res_ch, res_status;
  logic [RUN_W-1:0] res_run;
  logic [CNT_W-1:0] res_cycles;

  hls_run_sequencer #(.N_CH(N_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT),
                      .NUM_RUNS(NUM_RUNS), .RUN_W(RUN_W)) dut (
    .clock(clock), .reset(reset), .go(go), .dut_rst_n(dut_rst_n),
    .dut_start(dut_start), .dut_done(dut_done), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_run(res_run),
    .res_cycles(res_cycles), .res_status(res_status), .busy(busy),
    .batch_done(batch_done));

  always #5 clock = ~clock;

  typedef struct {int ch; int run; int cycles; int status; int rep_k;} rec_t;
  rec_t expq[$];
  int   rc_cycles[$], rc_status[$];
  int   tbl [3][3][4] = '{
    '{'{3, 7, 5, 2}, '{9, NEVER, 4, 19}, '{4, NEVER, NEVER, 0}},
    '{'{0, 1, 2, 3}, '{10, 10, 10, 10},  '{20, 1, 1, 1}},
    '{'{8, 8, 8, 8}, '{8, 8, 8, 8},      '{8, 8, 8, 8}}};
  int   offs[4] = '{NEVER, NEVER, NEVER, NEVER};
  int   bsel = 0, run_ctr = 0, k_off = -1, stall = 0, wait_cnt = 0;
  bit   noise = 1'b0;
  int   n_checks = 0, n_fail = 0, cyc = 0, bd_count = 0, last_xfer = -10;
  bit   prev_valid = 1'b0, prev_ready = 1'b0;
  logic [2:0] hist = 3'b111;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record model: done k cycles after the start pulse is measured as k+1,
  // anything past TIMEOUT is reported as TIMEOUT with status 11.
  function automatic int exp_cycles(input int off);
    return (off + 1 <= TIMEOUT) ? off + 1 : TIMEOUT;
  endfunction
  function automatic int exp_status(input int off);
    return (off + 1 <= TIMEOUT) ? 0 : 3;
  endfunction

  task automatic tick();
    int mx;
    bit lost;
    @(posedge clock); #2;
    if (dut_start !== '0) begin
      k_off = 0;
      offs  = (run_ctr < 3) ? tbl[bsel][run_ctr] : '{NEVER, NEVER, NEVER, NEVER};
      mx = 0; lost = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (exp_status(offs[i]) != 0) lost = 1'b1;
        else if (offs[i] > mx) mx = offs[i];
      end
      for (int i = 0; i < N_CH; i++)
        expq.push_back('{i, run_ctr, exp_cycles(offs[i]), exp_status(offs[i]),
                         lost ? TIMEOUT : mx + 1});
      run_ctr++;
    end else if (k_off >= 0) begin
      k_off++;
    end
    for (int i = 0; i < N_CH; i++) dut_done[i] = noise | (k_off >= 0 && k_off == offs[i]);
    if (res_valid) begin
      if (wait_cnt < stall) begin res_ready = 1'b0; wait_cnt++; end
      else begin res_ready = 1'b1; wait_cnt = 0; end
    end else begin
      res_ready = (stall == 0);
      wait_cnt  = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dut_rst_n"}, dut_rst_n, 0);
    check({tag, "_dut_start"}, dut_start, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_batch_done"}, batch_done, 0);
    check({tag, "_res_data"}, {res_ch, res_run, res_cycles, res_status}, 0);
  endtask

  task automatic run_batch(input int b, input bit inject_go);
    bit fin = 1'b0;
    bsel = b; run_ctr = 0;
    go = 1'b1; tick(); go = 1'b0;
    for (int i = 0; i < 600 && !fin; i++) begin
      tick();
      go = inject_go && (i == 10);
      if (batch_done === 1'b1) fin = 1'b1;
    end
    go = 1'b0;
    check("batch_completed", fin, 1);
    check("runs_started", run_ctr, NUM_RUNS);
  endtask

  // Compare process: records against the model queue, plus handshake,
  // start/reset sequencing and batch_done placement.
  always @(negedge clock) begin
    if (reset) begin
      if (res_valid) begin
        if (expq.size() == 0) begin
          check("unexpected_record", res_valid, 0);
        end else begin
          check("record", {res_ch, res_run, res_cycles, res_status},
                {expq[0].ch[1:0], expq[0].run[RUN_W-1:0], expq[0].cycles[CNT_W-1:0],
                 expq[0].status[1:0]});
          if (!prev_valid && expq[0].ch == 0) check("report_timing", k_off, expq[0].rep_k);
          if (res_ready) begin
            rc_cycles.push_back(int'(res_cycles));
            rc_status.push_back(int'(res_status));
            void'(expq.pop_front());
            last_xfer = cyc;
          end
        end
      end
      if (prev_valid && !prev_ready) check("valid_held", res_valid, 1);
      if (dut_start !== '0) begin
        check("start_pattern", dut_start, 4'hF);
        check("rst_before_start", {hist, dut_rst_n}, 4'b1001);
      end
      if (res_valid || dut_start !== '0) check("busy_active", busy, 1);
      if (batch_done) begin
        bd_count++;
        check("batch_done_queue_empty", expq.size(), 0);
        check("batch_done_timing", cyc, last_xfer + 1);
      end
      hist       = {hist[1:0], dut_rst_n};
      prev_valid = res_valid;
      prev_ready = res_ready;
    end else begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end
  end

  initial begin
    bit entered;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("por");
    @(posedge clock); #2 reset = 1'b1;
    @(negedge clock);
    check("rst_n_still_low", dut_rst_n, 0);
    @(negedge clock);
    check("rst_n_after_release", dut_rst_n, 1);
    repeat (3) tick();

    // Batch 1: no backpressure; ordering, timeout, done-at-limit.
    stall = 0;
    run_batch(0, 1'b0);
    check("pin_b1r0_c0", rc_cycles[0], 4);
    check("pin_b1r0_c1", rc_cycles[1], 8);
    check("pin_b1r0_c2", rc_cycles[2], 6);
    check("pin_b1r0_c3", rc_cycles[3], 3);
    check("pin_b1r1_c1_cycles", rc_cycles[5], 20);
    check("pin_b1r1_c1_status", rc_status[5], 3);
    check("pin_b1r1_c3_cycles", rc_cycles[7], 20);
    check("pin_b1r1_c3_status", rc_status[7], 0);
    repeat (3) tick();

    // Batch 2: 5-cycle stalls per record, a stray go mid-batch, late done ignored.
    stall = 5;
    run_batch(1, 1'b1);
    stall = 0;
    noise = 1'b1;
    repeat (10) tick();
    noise = 1'b0;
    check("idle_after_batch2", busy, 0);
    check("batch_done_count2", bd_count, 2);
    check("records_after_batch2", rc_cycles.size(), 24);
    check("pin_b2r2_c0_status", rc_status[20], 3);
    check("pin_b2r2_c1_cycles", rc_cycles[21], 2);

    // Batch 3: reset while waiting for dones aborts the batch.
    bsel = 2; run_ctr = 0;
    go = 1'b1; tick(); go = 1'b0;
    entered = 1'b0;
    for (int i = 0; i < 50 && !entered; i++) begin
      tick();
      if (k_off == 3) entered = 1'b1;
    end
    check("abort_reached_wait", entered, 1);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("abort");
    expq.delete();
    k_off = -1;
    @(posedge clock); #2 reset = 1'b1;
    noise = 1'b1;
    repeat (40) tick();
    noise = 1'b0;
    check("abort_no_batch_done", bd_count, 2);
    check("abort_no_records", rc_cycles.size(), 24);
    check("abort_idle", busy, 0);
    check("abort_rst_n_high", dut_rst_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hls_run_sequencer.md
HLS_RUN_SEQUENCER -- requirements
Module: hls_run_sequencer

Interface
REQ-001 SHALL have parameter N_CH, default 1, number of DUT channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, cycle-counter width.
REQ-003 SHALL have parameter TIMEOUT, default 200000000, maximum cycles per run (>=2, < 2^CNT_W).
REQ-004 SHALL have parameter NUM_RUNS, default 1, runs per batch (1..2^RUN_W-1).
REQ-005 SHALL have parameter RUN_W, default 16, run-index width.
REQ-006 SHALL have one clock, named clock, with synchronous active-low reset named reset.
REQ-007 Port list:
  clock  in  1  system clock
  reset  in  1  synchronous, active-low
  go  in  1  single-cycle batch start request
  dut_rst_n  out  1  active-low reset to all DUT channels
  dut_start  out  N_CH  per-channel start_port pulse
  dut_done  in  N_CH  per-channel done_port
  res_valid  out  1  result record valid
  res_ready  in  1  result record accepted
  res_ch  out  max(1,clog2(N_CH))  channel index of record
  res_run  out  RUN_W  run index of record, 0-based
  res_cycles  out  CNT_W  measured cycles
  res_status  out  2  00 completed, 11 timeout
  busy  out  1  batch in progress
  batch_done  out  1  one-cycle end-of-batch pulse

Function
REQ-008 SHALL implement states IDLE, SETUP, START, WAIT, REPORT, FINISH.
REQ-009 IDLE: go=1 -> SETUP, run index cleared to 0; busy=1 in every state except IDLE.
REQ-010 SETUP: dut_rst_n=0 for exactly 2 cycles, then -> START.
REQ-011 START: dut_start all bits =1 for exactly one cycle; counter loaded with 1; per-channel captured flags cleared; -> WAIT.
REQ-012 Counter SHALL count cycles since the start cycle: value 1 in START, incremented each WAIT cycle, saturating at TIMEOUT.
REQ-013 dut_done[i] sampled in START or WAIT with channel i not yet captured SHALL latch the current counter value, status 00, and set the flag.
REQ-014 dut_done in any other state, or on an already-captured channel, SHALL be ignored.
REQ-015 All flags set -> REPORT on the next cycle.
REQ-016 Counter == TIMEOUT with any flag clear SHALL record cycles=TIMEOUT, status 11 for each uncaptured channel, then -> REPORT; a done arriving in that same cycle SHALL win (status 00).
REQ-017 REPORT SHALL emit N_CH records, channel 0 first, ascending.
REQ-018 res_valid/res_ready: transfer on cycle both high; payload stable and res_valid held while res_ready=0; next record presented the cycle after a transfer, no bubble.
REQ-019 After last record: run index < NUM_RUNS-1 -> increment, SETUP; else -> FINISH.
REQ-020 FINISH: batch_done=1 for one cycle, -> IDLE.
REQ-021 go outside IDLE SHALL be ignored.
REQ-022 dut_rst_n SHALL be 1 in every state except SETUP.

Reset
REQ-023 reset=0 at clock edge: state IDLE, counter, run index, flags cleared; dut_rst_n=0, dut_start=0, res_valid=0, busy=0, batch_done=0, res_* data=0.
REQ-024 dut_rst_n SHALL stay 0 while reset=0 and become 1 the cycle after reset releases.
REQ-025 Reset mid-batch SHALL abort it: no further records, no batch_done.

Verification
REQ-026 N_CH=1, NUM_RUNS=1, go, done 9 cycles after start pulse, res_ready=1 -> one record ch0 run0 cycles=10 status 00, batch_done one cycle later.
REQ-027 N_CH=4, dones at cycles 3,7,5,2 after start -> records in order ch0..3 with cycles 4,8,6,3, REPORT only after the 4th done.
REQ-028 TIMEOUT=20, N_CH=2, ch0 done at count 5, ch1 never -> ch0 cycles=5 status 00, ch1 cycles=20 status 11; ch1 done exactly at count 20 -> status 00 cycles=20.
REQ-029 NUM_RUNS=3, res_ready low 5 cycles per record -> payload stable while stalled, run indices 0,1,2, dut_rst_n low 2 cycles before each dut_start pulse.
REQ-030 reset=0 asserted in WAIT -> all outputs at reset values next cycle; go issued during batch -> no effect; done pulse while IDLE -> no record.
